fir_band_sched: RTL and testbench
=================================

Name: fir_band_sched

Overview:
- Sequencer for the equalizer's bank of FIR band engines. Each engine takes one `seq` input, holds a 1-cycle ROM latency, and accumulates while `seq` is high.
- On every new stereo sample, the block owns the shared circular sample-buffer pointers and writes the sample.
- It then streams the last TAPS samples out of the buffer, aligned to every enabled band's `seq` window, and flags when band outputs are valid.
- It sits between the codec sample strobe and the band filters/summer.

Parameters:
- NUM_BANDS, 5, number of FIR band engines driven.
- TAPS, 1021, coefficients per band; one buffer read per tap.
- AW, 10, sample-buffer address width; buffer depth = 2^AW, and 2^AW >= TAPS+2 is required.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- smpl_vld  in  1  one-cycle strobe; new L/R sample present at buffer write data.
- band_en  in  NUM_BANDS  band enable mask; sampled at computation start.
- ovr_clr  in  1  clears sticky overrun flag.
- buf_we  out  1  sample-buffer write enable.
- buf_waddr  out  AW  sample-buffer write address.
- buf_raddr  out  AW  sample-buffer read address; buffer read data is available 1 cycle later.
- seq  out  NUM_BANDS  per-band sequence enable to the FIR engines.
- busy  out  1  computation in progress.
- out_vld  out  1  one-cycle pulse; band outputs are final.
- primed  out  1  buffer holds >= TAPS samples.
- overrun  out  1  sticky; a sample arrived while busy.

Behaviour:
- Reset values: wptr=0, fill_cnt=0, tap_cnt=0, state=IDLE, en_q=0. All outputs are 0, including buf_raddr=0 and buf_waddr=0.
- Reset asserted mid-computation drops `seq` on the next edge. No out_vld pulse is produced.
- Write path:
  - buf_we = smpl_vld (combinational) in every state; buf_waddr = wptr.
  - When smpl_vld is high, wptr <= wptr+1 (mod 2^AW) and fill_cnt saturating-increments to TAPS.
  - primed = (fill_cnt == TAPS).
- States:
  - IDLE:
    - Start condition: smpl_vld && (fill_cnt == TAPS, or fill_cnt == TAPS-1, i.e. this write primes the buffer).
    - On start: go to RUN; en_q <= band_en; tap_cnt <= 0; base <= wptr - (TAPS-1) (mod 2^AW), the oldest sample of the window with the new sample included.
    - If smpl_vld arrives while not yet primed, the sample is written and the block stays in IDLE.
  - RUN:
    - Lasts TAPS+1 cycles, numbered c=0..TAPS.
    - seq = en_q for the whole state.
    - buf_raddr = base + tap_cnt (mod 2^AW) for c=0..TAPS-1, so tap k is read on cycle k and its data reaches the FIR on cycle k+1, aligned with the engine's ROM output.
    - tap_cnt increments each cycle; at tap_cnt==TAPS go to DONE.
  - DONE:
    - One cycle; seq=0; out_vld=1; next state IDLE.
- busy = (state != IDLE).
- A new computation can start on the cycle after DONE at the earliest.
- buf_raddr holds its last value when not in RUN.
- Overrun:
  - smpl_vld while busy still writes the sample and advances wptr/fill_cnt, but does not start or restart a computation.
  - That sample is not filtered; overrun <= 1.
  - ovr_clr clears overrun. If ovr_clr and a new overrun event occur in the same cycle, overrun stays 1.
- Address wrap: every pointer addition wraps mod 2^AW. There is no special case at the boundary.
- band_en changes during RUN have no effect until the next start.
- If en_q == 0, the full timing still runs and out_vld still pulses, with seq all zero.
- Sizing: with TAPS=1021 and 2^AW=1024, a sample written during RUN never overwrites an in-window address.

Test Plan (bench params NUM_BANDS=3, TAPS=4, AW=3):
- Reset, then 3 smpl_vld pulses spaced 10 cycles -> buf_waddr = 0,1,2; seq stays 0; primed=0; out_vld never pulses.
- Fourth smpl_vld with band_en=3'b101 -> next cycle busy=1, seq=3'b101 for exactly 5 cycles; buf_raddr = 0,1,2,3 on c=0..3; out_vld pulses 1 cycle after seq falls; busy returns to 0.
- Continue to wptr wrap, with the 9th sample written at addr 0 -> window base=5; buf_raddr = 5,6,7,0.
- smpl_vld 2 cycles into RUN -> buf_we=1 at addr=wptr; overrun=1; seq window unchanged at 5 cycles; one out_vld only. Then ovr_clr -> overrun=0.
- band_en changed from 3'b111 to 3'b010 mid-RUN -> seq stays 3'b111 until DONE; next computation uses 3'b010.
- rst asserted at c=2 of RUN -> next edge: seq=0, busy=0, fill_cnt=0, primed=0, no out_vld; the following single smpl_vld does not start a computation.

Source files
------------

// File: rtl/fir_band_sched.sv
// fir_band_sched: sequencer for the equalizer FIR band engines.
// It owns the circular sample-buffer pointers and writes each new sample.
// It then replays the last TAPS samples under each enabled band's seq window.
module fir_band_sched #(
  parameter int NUM_BANDS = 5,
  parameter int TAPS      = 1021,
  parameter int AW        = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 smpl_vld,
  input  logic [NUM_BANDS-1:0] band_en,
  input  logic                 ovr_clr,
  output logic                 buf_we,
  output logic [AW-1:0]        buf_waddr,
  output logic [AW-1:0]        buf_raddr,
  output logic [NUM_BANDS-1:0] seq,
  output logic                 busy,
  output logic                 out_vld,
  output logic                 primed,
  output logic                 overrun
);

  localparam int            CW     = $clog2(TAPS + 1);
  localparam logic [CW-1:0] TAPS_C = CW'(TAPS);
  localparam logic [CW-1:0] TM1_C  = CW'(TAPS - 1);
  // distance from the newest sample back to the oldest tap of the window
  localparam logic [AW-1:0] BACK   = AW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         base;
  logic [CW-1:0]         fill_cnt;
  logic [CW-1:0]         tap_cnt;
  logic [NUM_BANDS-1:0]  en_q;

  assign buf_we    = smpl_vld;
  assign buf_waddr = wptr;
  assign primed    = (fill_cnt == TAPS_C);

  // Write side: every strobe lands in the buffer, even mid-computation.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      fill_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      if (smpl_vld) begin
        wptr <= wptr + 1'b1;
        if (fill_cnt != TAPS_C) fill_cnt <= fill_cnt + 1'b1;
      end
      // a new event wins over a simultaneous clear
      if (smpl_vld && busy)  overrun <= 1'b1;
      else if (ovr_clr)      overrun <= 1'b0;
    end
  end

  // Sequencer: IDLE -> RUN (TAPS+1 cycles) -> DONE (out_vld) -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      base      <= '0;
      en_q      <= '0;
      seq       <= '0;
      busy      <= 1'b0;
      out_vld   <= 1'b0;
      buf_raddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_vld <= 1'b0;
          // the write happening now may be the one that primes the buffer
          if (smpl_vld && (fill_cnt >= TM1_C)) begin
            state     <= RUN;
            en_q      <= band_en;
            seq       <= band_en;
            busy      <= 1'b1;
            tap_cnt   <= '0;
            base      <= wptr - BACK;
            buf_raddr <= wptr - BACK;
          end
        end
        RUN: begin
          if (tap_cnt == TAPS_C) begin
            // last data beat has been consumed by the engines
            state   <= DONE;
            seq     <= '0;
            out_vld <= 1'b1;
          end else begin
            seq     <= en_q;
            tap_cnt <= tap_cnt + 1'b1;
            // raddr is registered, so issue tap k+1 while showing tap k;
            // after the last tap it simply holds
            if (tap_cnt != TM1_C)
              buf_raddr <= base + AW'(tap_cnt) + AW'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          out_vld <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          seq     <= '0;
          busy    <= 1'b0;
          out_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_band_sched.sv
// Bench for fir_band_sched with NUM_BANDS=3, TAPS=4, AW=3.
// Reference: a timeline model counting edges since each computation start.
module tb_fir_band_sched;

  localparam int NB   = 3;
  localparam int TAPS = 4;
  localparam int AW   = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          smpl_vld;
  logic [NB-1:0] band_en;
  logic          ovr_clr;
  logic          buf_we;
  logic [AW-1:0] buf_waddr, buf_raddr;
  logic [NB-1:0] seq;
  logic          busy, out_vld, primed, overrun;

  fir_band_sched #(.NUM_BANDS(NB), .TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .band_en(band_en),
    .ovr_clr(ovr_clr), .buf_we(buf_we), .buf_waddr(buf_waddr),
    .buf_raddr(buf_raddr), .seq(seq), .busy(busy), .out_vld(out_vld),
    .primed(primed), .overrun(overrun));

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {seq, busy, out_vld, primed, overrun, buf_waddr, buf_raddr};

  int n_chk = 0;
  int n_pass = 0;

  // model state
  int          m_wptr, m_fill, m_k, m_base, m_raddr;
  logic        m_ovr;
  logic [NB-1:0] m_en;

  // m_k = edges since the start edge (0 = idle); seq for k=1..TAPS+1,
  // out_vld at k=TAPS+2, tap j shown at k=j+1
  task automatic model_edge();
    int nk;
    if (rst) begin
      m_wptr = 0; m_fill = 0; m_k = 0; m_base = 0; m_raddr = 0;
      m_ovr = 1'b0; m_en = '0;
    end else begin
      nk = (m_k == 0 || m_k >= TAPS + 2) ? 0 : m_k + 1;
      if (smpl_vld && m_k == 0 && m_fill >= TAPS - 1) begin
        m_base = (m_wptr + DEPTH - (TAPS - 1)) % DEPTH;
        m_en   = band_en;
        nk     = 1;
      end
      if (smpl_vld && m_k != 0) m_ovr = 1'b1;
      else if (ovr_clr)         m_ovr = 1'b0;
      if (smpl_vld) begin
        m_wptr = (m_wptr + 1) % DEPTH;
        if (m_fill < TAPS) m_fill++;
      end
      m_k = nk;
      if (m_k >= 1 && m_k <= TAPS) m_raddr = (m_base + m_k - 1) % DEPTH;
    end
  endtask

  function automatic logic [12:0] exp_vec();
    logic [NB-1:0] s;
    s = (m_k >= 1 && m_k <= TAPS + 1) ? m_en : '0;
    return {s, (m_k != 0), (m_k == TAPS + 2), (m_fill == TAPS), m_ovr,
            AW'(m_wptr), AW'(m_raddr)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; smpl_vld = 1'b0; band_en = '0; ovr_clr = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    n_chk++;
    if (obs !== 13'd0) $display("FAIL reset_zero: got %h expected 0", obs);
    else n_pass++;
    n_chk++;
    if (obs !== exp_vec()) $display("FAIL reset_model: got %h expected %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_prime();
    for (int s = 0; s < 3; s++) begin
      n_chk++;
      if (buf_waddr !== AW'(s)) $display("FAIL prime_waddr: got %0d expected %0d", buf_waddr, s);
      else n_pass++;
      smpl_vld = 1'b1; #1;
      n_chk++;
      if (buf_we !== 1'b1) $display("FAIL prime_we: got %b expected 1", buf_we);
      else n_pass++;
      cyc(); smpl_vld = 1'b0;
      for (int i = 0; i < 10; i++) begin
        n_chk++;
        if (obs !== exp_vec() || seq !== '0 || out_vld !== 1'b0 || primed !== 1'b0)
          $display("FAIL prime_idle: got %h expected %h", obs, exp_vec());
        else n_pass++;
        cyc();
      end
    end
  endtask

  task automatic test_first_run();
    int sc, oc, j;
    logic [AW-1:0] ra [4];
    sc = 0; oc = 0; j = 0;
    band_en = 3'b101; smpl_vld = 1'b1;
    cyc(); smpl_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL first_run_cyc%0d: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (seq == 3'b101) begin
        sc++;
        if (j < 4) ra[j] = buf_raddr;
        j++;
      end
      if (out_vld) oc++;
      cyc();
    end
    n_chk++;
    if (sc != 5 || oc != 1) $display("FAIL first_run_window: got seq=%0d vld=%0d expected 5 1", sc, oc);
    else n_pass++;
    n_chk++;
    if (ra[0] !== 3'd0 || ra[1] !== 3'd1 || ra[2] !== 3'd2 || ra[3] !== 3'd3)
      $display("FAIL first_run_raddr: got %0d %0d %0d %0d expected 0 1 2 3", ra[0], ra[1], ra[2], ra[3]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ra [4];
    int j;
    for (int s = 5; s <= 9; s++) begin
      j = 0;
      if (s == 9) begin
        n_chk++;
        if (buf_waddr !== 3'd0) $display("FAIL wrap_waddr: got %0d expected 0", buf_waddr);
        else n_pass++;
      end
      band_en = 3'b111; smpl_vld = 1'b1;
      cyc(); smpl_vld = 1'b0;
      for (int i = 0; i < 10; i++) begin
        n_chk++;
        if (obs !== exp_vec()) $display("FAIL wrap_s%0d_cyc%0d: got %h expected %h", s, i, obs, exp_vec());
        else n_pass++;
        if (seq != '0 && j < 4) begin ra[j] = buf_raddr; j++; end
        cyc();
      end
    end
    n_chk++;
    if (ra[0] !== 3'd5 || ra[1] !== 3'd6 || ra[2] !== 3'd7 || ra[3] !== 3'd0)
      $display("FAIL wrap_raddr: got %0d %0d %0d %0d expected 5 6 7 0", ra[0], ra[1], ra[2], ra[3]);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int sc, oc;
    for (int pass = 0; pass < 2; pass++) begin
      sc = 0; oc = 0;
      band_en = 3'b011; smpl_vld = 1'b1;
      cyc(); smpl_vld = 1'b0;
      for (int i = 0; i < 12; i++) begin
        n_chk++;
        if (obs !== exp_vec()) $display("FAIL ovr_p%0d_cyc%0d: got %h expected %h", pass, i, obs, exp_vec());
        else n_pass++;
        if (seq != '0) sc++;
        if (out_vld) oc++;
        if (i == 2) begin
          // second pass also asserts the clear in the same cycle
          smpl_vld = 1'b1; ovr_clr = (pass == 1); #1;
          n_chk++;
          if (buf_we !== 1'b1 || buf_waddr !== AW'(m_wptr))
            $display("FAIL ovr_write: got we=%b addr=%0d expected 1 %0d", buf_we, buf_waddr, m_wptr);
          else n_pass++;
          cyc(); smpl_vld = 1'b0; ovr_clr = 1'b0;
        end else cyc();
      end
      n_chk++;
      if (sc != 5 || oc != 1 || overrun !== 1'b1)
        $display("FAIL ovr_window_p%0d: got seq=%0d vld=%0d ovr=%b expected 5 1 1", pass, sc, oc, overrun);
      else n_pass++;
      ovr_clr = 1'b1; cyc(); ovr_clr = 1'b0;
      n_chk++;
      if (overrun !== 1'b0 || obs !== exp_vec()) $display("FAIL ovr_clear: got %b expected 0", overrun);
      else n_pass++;
    end
  endtask

  task automatic test_band_change();
    int sc1, sc2;
    sc1 = 0; sc2 = 0;
    band_en = 3'b111; smpl_vld = 1'b1;
    cyc(); smpl_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) band_en = 3'b010;
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL band_a_cyc%0d: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (seq == 3'b111) sc1++;
      cyc();
    end
    smpl_vld = 1'b1;
    cyc(); smpl_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL band_b_cyc%0d: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (seq == 3'b010) sc2++;
      cyc();
    end
    n_chk++;
    if (sc1 != 5 || sc2 != 5) $display("FAIL band_change: got %0d %0d expected 5 5", sc1, sc2);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      smpl_vld = ($urandom_range(0, 5) == 0);
      band_en  = NB'($urandom);
      ovr_clr  = ($urandom_range(0, 7) == 0);
      #1;
      n_chk++;
      if (buf_we !== smpl_vld) $display("FAIL rand_we_cyc%0d: got %b expected %b", i, buf_we, smpl_vld);
      else n_pass++;
      cyc();
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL rand_cyc%0d: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
    end
    smpl_vld = 1'b0; ovr_clr = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
  endtask

  task automatic test_reset_mid();
    int oc;
    oc = 0;
    band_en = 3'b110; smpl_vld = 1'b1;
    cyc(); smpl_vld = 1'b0;
    cyc(); cyc();
    n_chk++;
    if (seq !== 3'b110 || busy !== 1'b1) $display("FAIL rmid_pre: got seq=%b busy=%b expected 110 1", seq, busy);
    else n_pass++;
    rst = 1'b1; cyc(); rst = 1'b0;
    n_chk++;
    if (seq !== '0 || busy !== 1'b0 || primed !== 1'b0 || out_vld !== 1'b0 || obs !== exp_vec())
      $display("FAIL rmid_post: got %h expected %h", obs, exp_vec());
    else n_pass++;
    smpl_vld = 1'b1; cyc(); smpl_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (obs !== exp_vec() || busy !== 1'b0) $display("FAIL rmid_idle_cyc%0d: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (out_vld) oc++;
      cyc();
    end
    n_chk++;
    if (oc != 0) $display("FAIL rmid_no_vld: got %0d expected 0", oc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_prime();
    test_first_run();
    test_wrap();
    test_overrun();
    test_band_change();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
